// File: rtl/wee_woo_pkg.sv
// Shared constants for the wee_woo police-light frame generator:
// LED word width, full-brightness GRB colours and phase encodings.
package wee_woo_pkg;

  localparam int unsigned LED_BITS = 24;

  // GRB words at full intensity; the top level rebuilds these from its own
  // BRIGHTNESS parameter when a dimmer strip is wanted.
  localparam logic [LED_BITS-1:0] COLOR_RED  = {8'h00, 8'hFF, 8'h00};
  localparam logic [LED_BITS-1:0] COLOR_BLUE = {8'h00, 8'h00, 8'hFF};
  localparam logic [LED_BITS-1:0] COLOR_OFF  = '0;

  // Phase sequence of the strobe variant: RB -> OFF -> BR -> OFF -> RB.
  // The plain variant only uses RB and BR, carried in a single bit.
  typedef enum logic [1:0] {
    PH_RB    = 2'd0,
    PH_OFF_A = 2'd1,
    PH_BR    = 2'd2,
    PH_OFF_B = 2'd3
  } phase_e;

endpackage

// File: rtl/wee_woo_tick_sync.sv
// Brings the (possibly asynchronous) 10 Hz input into the clk domain and
// emits a single-cycle tick for every rising edge it sees.
module tick_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tenHzIn,
  output logic tick
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   prevQ;
  logic                   syncOut;

  assign syncOut = syncQ[SYNC_STAGES-1];

  // Synchronizer chain followed by the previous-value flop for edge detection.
  // NOTE: non-blocking assignments keep every stage sampling the value from
  // before this edge; blocking ones would collapse the chain into one flop.
  // NOTE: every flop here clears on reset so no stale edge survives a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], tenHzIn};
      prevQ <= syncOut;
    end
  end

  assign tick = syncOut & ~prevQ;

endmodule

// File: rtl/wee_woo.sv
// Police-light ("wee-woo") GRB frame generator for a WS2812B strip.
// Each rising edge of tenHzIn advances the phase; the frame is a pure decode
// of the phase register. Define WEEWOO_STROBE_EN for the four-step
// RB -> OFF -> BR -> OFF sequence; otherwise the pattern toggles RB <-> BR.
module wee_woo
  import wee_woo_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 4,
  parameter logic [7:0]  BRIGHTNESS  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tenHzIn,
  output logic [LED_BITS*NUM_LEDS-1:0] rbSwap
);

  localparam logic [LED_BITS-1:0] RED_WORD  = {8'h00, BRIGHTNESS, 8'h00};
  localparam logic [LED_BITS-1:0] BLUE_WORD = {8'h00, 8'h00, BRIGHTNESS};

  logic tick;
  logic showOff;   // whole strip dark
  logic swapped;   // first half blue, second half red

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uTickSync (
    .clk    (clk),
    .reset  (reset),
    .tenHzIn(tenHzIn),
    .tick   (tick)
  );

`ifdef WEEWOO_STROBE_EN
  phase_e phase, phaseNext;

  // Phase register: advances one step of the strobe sequence per tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase <= PH_RB;
    else        phase <= phaseNext;
  end

  // Next phase and pattern selects for the four-step sequence.
  // NOTE: every output gets a default before any branch, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    phaseNext = phase;
    showOff   = 1'b0;
    swapped   = 1'b0;
    if (tick) begin
      case (phase)
        PH_RB:    phaseNext = PH_OFF_A;
        PH_OFF_A: phaseNext = PH_BR;
        PH_BR:    phaseNext = PH_OFF_B;
        PH_OFF_B: phaseNext = PH_RB;
      endcase
    end
    showOff = (phase == PH_OFF_A) || (phase == PH_OFF_B);
    swapped = (phase == PH_BR);
  end
`else
  logic phase, phaseNext;

  // Phase register: 0 = RB, 1 = BR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase <= 1'b0;
    else        phase <= phaseNext;
  end

  // Next phase and pattern selects for the two-step toggle.
  always_comb begin
    phaseNext = phase ^ tick;
    showOff   = 1'b0;
    swapped   = phase;
  end
`endif

  // Frame builder: LED0 sits in the MSBs and is shifted out first.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : gLed
    localparam bit FIRST_HALF = (i < NUM_LEDS / 2);
    assign rbSwap[LED_BITS*(NUM_LEDS-i)-1 -: LED_BITS] =
      showOff                  ? COLOR_OFF :
      (FIRST_HALF != swapped)  ? RED_WORD  : BLUE_WORD;
  end

endmodule

// File: tb/tb_wee_woo.sv
// Self-checking bench for wee_woo: directed scenarios plus randomized pulse
// trains, compared every cycle against a model that counts rising edges of
// the sampled input and maps the edge count to a frame.
module tb_wee_woo;

  localparam int NUM_LEDS = 4;
  localparam int W        = 24 * NUM_LEDS;
  localparam logic [W-1:0] FRAME_RB = 96'h00FF00_00FF00_0000FF_0000FF;
`ifdef WEEWOO_STROBE_EN
  localparam int MODULUS  = 4;
  localparam int BR_STEP  = 2;
`else
  localparam int MODULUS  = 2;
  localparam int BR_STEP  = 1;
  localparam logic [W-1:0] FRAME_BR = 96'h0000FF_0000FF_00FF00_00FF00;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         tenHzIn;
  logic [W-1:0] rbSwap;

  int tests = 0;
  int fails = 0;
  bit hist[$];   // tenHzIn as sampled at each clk edge since the last reset release

  wee_woo dut (
    .clk    (clk),
    .reset  (reset),
    .tenHzIn(tenHzIn),
    .rbSwap (rbSwap)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  // Expected frame after n ticks since reset.
  function automatic logic [W-1:0] expFrame(input int n);
    logic [W-1:0] f;
    int  p   = n % MODULUS;
    bit  off = (MODULUS == 4) && (p % 2 == 1);
    bit  sw  = (p == BR_STEP);
    for (int i = 0; i < NUM_LEDS; i++) begin
      logic [23:0] led;
      if (off)                     led = 24'h000000;
      else if ((i < NUM_LEDS/2) != sw) led = 24'h00FF00;
      else                         led = 24'h0000FF;
      f[W-1-24*i -: 24] = led;
    end
    return f;
  endfunction

  // A rising edge sampled at edge j is visible after edge j+2.
  function automatic int expCount();
    int c = 0;
    for (int j = 0; j + 3 <= hist.size(); j++)
      if (hist[j] && (j == 0 || !hist[j-1])) c++;
    return c;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] exp);
    tests++;
    assert (rbSwap === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, rbSwap, exp);
    end
  endtask

  // One clk cycle: drive level at negedge, record the sample, check at next negedge.
  task automatic cycle(input bit level, input string tag);
    tenHzIn = level;
    @(posedge clk);
    if (reset) hist.push_back(tenHzIn);
    @(negedge clk);
    check(tag, expFrame(expCount()));
  endtask

  initial begin
    // 1. Reset held with tenHzIn high: RB pattern.
    reset   = 1'b0;
    tenHzIn = 1'b1;
    #1;
    check("reset_rb_immediate", FRAME_RB);
    repeat (3) @(negedge clk);
    check("reset_rb_held", FRAME_RB);

    // 2. Release with input low, then raise it: change exactly two edges later.
    tenHzIn = 1'b0;
    reset   = 1'b1;
    hist.delete();
    cycle(1'b0, "idle_after_release");
    cycle(1'b1, "rise_edge_k");
    check("rise_edge_k_no_change", FRAME_RB);
    cycle(1'b1, "rise_edge_k1");
    check("rise_edge_k1_no_change", FRAME_RB);
    cycle(1'b1, "rise_edge_k2");
`ifdef WEEWOO_STROBE_EN
    check("rise_edge_k2_off", '0);
`else
    check("rise_edge_k2_br", FRAME_BR);
`endif

    // 3. Long high level then fall: still one toggle, fall does nothing.
    repeat (7) cycle(1'b1, "steady_high");
    repeat (4) cycle(1'b0, "falling_edge");
    check("one_toggle_total", expFrame(1));

    // 4. Two pulses 30 ns apart: two toggles.
    cycle(1'b1, "pulse_a");
    cycle(1'b0, "gap_a");
    cycle(1'b0, "gap_b");
    cycle(1'b1, "pulse_b");
    repeat (3) cycle(1'b0, "pulse_settle");
    check("two_more_toggles", expFrame(3));

    // Randomized pulse trains.
    for (int r = 0; r < 25; r++) begin
      int hi = $urandom_range(1, 5);
      int lo = $urandom_range(1, 5);
      repeat (hi) cycle(1'b1, "rand_high");
      repeat (lo) cycle(1'b0, "rand_low");
    end
    repeat (3) cycle(1'b0, "rand_drain");

    // 5. Reach BR, then assert reset mid-cycle: RB with no clk edge.
    for (int g = 0; g < 8 && (expCount() % MODULUS) != BR_STEP; g++) begin
      cycle(1'b1, "seek_br_high");
      repeat (2) cycle(1'b0, "seek_br_low");
    end
    check("in_br_before_reset", expFrame(BR_STEP));
    #2;
    reset = 1'b0;
    hist.delete();
    #1;
    check("async_reset_rb", FRAME_RB);

    // A rise captured just before reset must not survive it.
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, "pending_rise");
    #2;
    reset = 1'b0;
    hist.delete();
    #1;
    check("pending_reset_rb", FRAME_RB);
    @(negedge clk);
    tenHzIn = 1'b0;
    reset   = 1'b1;
    repeat (4) cycle(1'b0, "no_pending_tick");
    check("pending_dropped", FRAME_RB);

    // Input high at reset release: exactly one tick.
    reset = 1'b0;
    tenHzIn = 1'b1;
    hist.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (6) cycle(1'b1, "high_at_release");
    check("high_at_release_one_tick", expFrame(1));

    // 6. Four pulses walk the full sequence (two-step toggle without strobe).
    repeat (2) cycle(1'b0, "seq_idle");
    for (int s = 2; s <= 5; s++) begin
      cycle(1'b1, "seq_high");
      repeat (3) cycle(1'b0, "seq_low");
      check("seq_step", expFrame(s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
